axi_slave_mem: RTL

//  AXI4 memory responder: accepts one read or write burst at a time and serves it

---
 rtl/axi_slave_mem.sv | 324 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_slave_mem.sv
// AXI4 memory responder: serves one read or write burst at a time from an
// internal word-addressed RAM. Beats are fixed at 4 bytes. Address bits [1:0]
// are ignored. Out-of-range, wrapped, mis-sized or non FIXED/INCR beats are
// answered with SLVERR and never touch the RAM.
//
// Handshake rule on every channel: a transfer happens on the rising aclk edge
// where both valid and ready are high. Once a valid is raised by this block,
// the payload stays stable until ready is seen. While AR and AW are both
// offered in IDLE, awready is held low so that only the read is accepted.
// The master keeps AW pending until the read burst has finished.
module axi_slave_mem #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 256
) (
   input  logic                    aclk,
   input  logic                    areset_n,
   // write address channel
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [7:0]              awlen,
   input  logic [2:0]              awsize,
   input  logic [1:0]              awburst,
   input  logic                    awvalid,
   output logic                    awready,
   // write data channel
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wlast,
   input  logic                    wvalid,
   output logic                    wready,
   // write response channel
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   // read address channel
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic [7:0]              arlen,
   input  logic [2:0]              arsize,
   input  logic [1:0]              arburst,
   input  logic                    arvalid,
   output logic                    arready,
   // read data channel
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    rlast,
   output logic                    rvalid,
   input  logic                    rready,
   // current FSM state (IDLE=0, RDATA=1, WDATA=2, WRESP=3)
   output logic [1:0]              dbg_state
);

   localparam int         STRB_W      = DATA_WIDTH / 8;
   localparam int         IDX_W       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [2:0] SIZE_4B     = 3'b010;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RDATA = 2'd1,
      WDATA = 2'd2,
      WRESP = 2'd3
   } state_t;

   // A beat is in error if its word is outside the RAM, the address wrapped
   // past the top of the address space, or the burst attributes are illegal.
   function automatic logic beat_err(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [2:0]            size,
                                     input logic [1:0]            burst,
                                     input logic                  wrapped);
      beat_err = wrapped
              || ((addr >> 2) >= ADDR_WIDTH'(MEM_DEPTH))
              || (size != SIZE_4B)
              || ((burst != BURST_FIXED) && (burst != BURST_INCR));
   endfunction

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [7:0]              len_q, len_d;
   logic [7:0]              beat_q, beat_d;
   logic [2:0]              size_q, size_d;
   logic [1:0]              burst_q, burst_d;
   logic                    wrap_q, wrap_d;
   logic                    err_q, err_d;
   logic                    arready_q, arready_d;
   logic                    awready_q, awready_d;
   logic                    wready_q, wready_d;
   logic                    rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;
   logic                    rlast_q, rlast_d;
   logic                    bvalid_q, bvalid_d;
   logic [1:0]              bresp_q, bresp_d;

   logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

   logic [ADDR_WIDTH:0]     addr_sum;
   logic [ADDR_WIDTH-1:0]   nxt_addr;
   logic                    nxt_wrap;
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic [2:0]              rd_size;
   logic [1:0]              rd_burst;
   logic                    rd_wrap;
   logic                    rd_err;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic                    wr_err;
   logic                    wr_last;
   logic                    mem_we;
   logic [IDX_W-1:0]        mem_widx;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [STRB_W-1:0]       mem_wstrb;
   logic                    ar_hs, aw_hs, w_hs, r_hs, b_hs;

   assign arready   = arready_q;
   assign awready   = awready_q && !arvalid;
   assign wready    = wready_q;
   assign rvalid    = rvalid_q;
   assign rdata     = rdata_q;
   assign rresp     = rresp_q;
   assign rlast     = rlast_q;
   assign bvalid    = bvalid_q;
   assign bresp     = bresp_q;
   assign dbg_state = state_q;

   assign ar_hs = arvalid && arready;
   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready_q;
   assign r_hs  = rvalid_q && rready;
   assign b_hs  = bvalid_q && bready;

   // Address of the following beat; the carry out marks a wrap that must error.
   assign addr_sum = {1'b0, addr_q} + (ADDR_WIDTH+1)'(4);
   assign nxt_addr = (burst_q == BURST_INCR) ? addr_sum[ADDR_WIDTH-1:0] : addr_q;
   assign nxt_wrap = wrap_q || ((burst_q == BURST_INCR) && addr_sum[ADDR_WIDTH]);
   assign wr_err   = beat_err(addr_q, size_q, burst_q, wrap_q);

   // Read lookup: first beat comes from the AR request, later beats from the next address.
   always_comb begin
      if (state_q == IDLE) begin
         rd_addr  = araddr;
         rd_size  = arsize;
         rd_burst = arburst;
         rd_wrap  = 1'b0;
      end else begin
         rd_addr  = nxt_addr;
         rd_size  = size_q;
         rd_burst = burst_q;
         rd_wrap  = nxt_wrap;
      end
      rd_err  = beat_err(rd_addr, rd_size, rd_burst, rd_wrap);
      rd_word = rd_err ? '0 : mem[IDX_W'(rd_addr >> 2)];
   end

   // Next-state and next-output logic for the burst FSM.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      beat_d    = beat_q;
      size_d    = size_q;
      burst_d   = burst_q;
      wrap_d    = wrap_q;
      err_d     = err_q;
      arready_d = arready_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rlast_d   = rlast_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      mem_we    = 1'b0;
      mem_widx  = IDX_W'(addr_q >> 2);
      mem_wdata = wdata;
      mem_wstrb = wstrb;
      wr_last   = (beat_q == len_q);

      case (state_q)
         IDLE: begin
            arready_d = 1'b1;
            awready_d = 1'b1;
            if (ar_hs) begin
               addr_d    = araddr;
               len_d     = arlen;
               size_d    = arsize;
               burst_d   = arburst;
               beat_d    = 8'd0;
               wrap_d    = 1'b0;
               rvalid_d  = 1'b1;
               rdata_d   = rd_word;
               rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
               rlast_d   = (arlen == 8'd0);
               arready_d = 1'b0;
               awready_d = 1'b0;
               state_d   = RDATA;
            end else if (aw_hs) begin
               addr_d    = awaddr;
               len_d     = awlen;
               size_d    = awsize;
               burst_d   = awburst;
               beat_d    = 8'd0;
               wrap_d    = 1'b0;
               err_d     = 1'b0;
               wready_d  = 1'b1;
               arready_d = 1'b0;
               awready_d = 1'b0;
               state_d   = WDATA;
            end
         end

         RDATA: begin
            if (r_hs) begin
               if (rlast_q) begin
                  rvalid_d  = 1'b0;
                  rdata_d   = '0;
                  rresp_d   = RESP_OKAY;
                  rlast_d   = 1'b0;
                  arready_d = 1'b1;
                  awready_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  addr_d  = nxt_addr;
                  wrap_d  = nxt_wrap;
                  beat_d  = 8'(beat_q + 8'd1);
                  rdata_d = rd_word;
                  rresp_d = rd_err ? RESP_SLVERR : RESP_OKAY;
                  rlast_d = (8'(beat_q + 8'd1) == len_q);
               end
            end
         end

         WDATA: begin
            if (w_hs) begin
               mem_we = !wr_err;
               if (wr_err || (wlast != wr_last)) begin
                  err_d = 1'b1;
               end
               if (wr_last) begin
                  wready_d = 1'b0;
                  bvalid_d = 1'b1;
                  bresp_d  = err_d ? RESP_SLVERR : RESP_OKAY;
                  state_d  = WRESP;
               end else begin
                  addr_d = nxt_addr;
                  wrap_d = nxt_wrap;
                  beat_d = 8'(beat_q + 8'd1);
               end
            end
         end

         WRESP: begin
            if (b_hs) begin
               bvalid_d  = 1'b0;
               bresp_d   = RESP_OKAY;
               arready_d = 1'b1;
               awready_d = 1'b1;
               state_d   = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // FSM state, burst context and registered channel outputs.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         wrap_q    <= 1'b0;
         err_q     <= 1'b0;
         arready_q <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         rlast_q   <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         beat_q    <= beat_d;
         size_q    <= size_d;
         burst_q   <= burst_d;
         wrap_q    <= wrap_d;
         err_q     <= err_d;
         arready_q <= arready_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   // RAM storage: cleared on reset, byte-lane writes from accepted W beats.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (mem_wstrb[b]) begin
               mem[mem_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
         end
      end
   end

endmodule
